// File: rtl/sm83_seq_param.sv
// Parametrised SM83 machine-cycle / T-state sequencer: one-hot M and T strobes,
// stall, T resync, and sticky overflow / protocol-error flags.
module sm83_seq_param #(
  parameter int unsigned MCYC    = 6,
  parameter int unsigned TSTATES = 4,
  localparam int unsigned MW     = $clog2(MCYC)
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               ncyc,
  input  logic               stall,
  input  logic               set_m1,
  output logic [MCYC-1:0]    m,
  output logic [TSTATES-1:0] t,
  output logic [MW-1:0]      m_idx,
  output logic               t_last,
  output logic               m_end,
  output logic               m_ovf,
  output logic               proto_err
);

  if (MCYC < 2 || MCYC > 16) begin : g_bad_mcyc
    $error("sm83_seq_param: MCYC=%0d outside 2..16", MCYC);
  end
  if (TSTATES < 2 || TSTATES > 8) begin : g_bad_tstates
    $error("sm83_seq_param: TSTATES=%0d outside 2..8", TSTATES);
  end

  assign t_last = t[TSTATES-1];
  assign m_end  = t_last && !stall;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      t         <= TSTATES'(1);
      m         <= MCYC'(1);
      m_idx     <= '0;
      m_ovf     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (ncyc) begin
        t <= TSTATES'(1);
      end else if (!stall) begin
        t <= {t[TSTATES-2:0], t[TSTATES-1]};
      end

      // M only moves on the unstalled last T-state; ncyc does not gate it.
      if (m_end) begin
        if (set_m1) begin
          m     <= MCYC'(1);
          m_idx <= '0;
        end else if (!m[MCYC-1]) begin
          m     <= {m[MCYC-2:0], 1'b0};
          m_idx <= m_idx + MW'(1);
        end else begin
          m_ovf <= 1'b1;
        end
      end

      if (set_m1 && !t_last) begin
        proto_err <= 1'b1;
      end
    end
  end

  a_t_onehot: assert property (@(posedge clk) disable iff (!nreset) $onehot(t));
  a_m_onehot: assert property (@(posedge clk) disable iff (!nreset) $onehot(m));
  a_m_idx:    assert property (@(posedge clk) disable iff (!nreset) m == (MCYC'(1) << m_idx));
  a_m_end:    assert property (@(posedge clk) disable iff (!nreset) !m_end || t_last);

endmodule

// File: tb/tb_sm83_seq_param.sv
// Bench for sm83_seq_param: two configurations (6x4 and 3x2) driven in lockstep and
// compared every clock against an integer-position reference model.
module tb_sm83_seq_param;

  logic clk = 1'b0;
  logic nreset, ncyc, stall, set_m1;
  always #5 clk = ~clk;

  logic [5:0] m_a;  logic [3:0] t_a;  logic [2:0] idx_a;
  logic       t_last_a, m_end_a, ovf_a, perr_a;
  logic [2:0] m_b;  logic [1:0] t_b;  logic [1:0] idx_b;
  logic       t_last_b, m_end_b, ovf_b, perr_b;

  sm83_seq_param #(.MCYC(6), .TSTATES(4)) dut_a (
    .clk(clk), .nreset(nreset), .ncyc(ncyc), .stall(stall), .set_m1(set_m1),
    .m(m_a), .t(t_a), .m_idx(idx_a), .t_last(t_last_a), .m_end(m_end_a),
    .m_ovf(ovf_a), .proto_err(perr_a)
  );

  sm83_seq_param #(.MCYC(3), .TSTATES(2)) dut_b (
    .clk(clk), .nreset(nreset), .ncyc(ncyc), .stall(stall), .set_m1(set_m1),
    .m(m_b), .t(t_b), .m_idx(idx_b), .t_last(t_last_b), .m_end(m_end_b),
    .m_ovf(ovf_b), .proto_err(perr_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current T and M positions as plain integers.
  int tn[2] = '{4, 2};
  int mn[2] = '{6, 3};
  int tp[2];
  int mp[2];
  bit ovf[2];
  bit perr[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      tp[i] = 0; mp[i] = 0; ovf[i] = 1'b0; perr[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit nc, input bit st, input bit s1);
    for (int i = 0; i < 2; i++) begin
      bit last;
      last = (tp[i] == tn[i] - 1);
      if (s1 && !last) perr[i] = 1'b1;
      if (last && !st) begin
        if (s1)                   mp[i] = 0;
        else if (mp[i] < mn[i]-1) mp[i] = mp[i] + 1;
        else                      ovf[i] = 1'b1;
      end
      if (nc)       tp[i] = 0;
      else if (!st) tp[i] = (tp[i] + 1) % tn[i];
    end
  endtask

  task automatic check_state(input string where);
    check({where, ":t_a"},    32'(t_a),    32'(1) << tp[0]);
    check({where, ":m_a"},    32'(m_a),    32'(1) << mp[0]);
    check({where, ":idx_a"},  32'(idx_a),  32'(mp[0]));
    check({where, ":ovf_a"},  32'(ovf_a),  32'(ovf[0]));
    check({where, ":perr_a"}, 32'(perr_a), 32'(perr[0]));
    check({where, ":t_b"},    32'(t_b),    32'(1) << tp[1]);
    check({where, ":m_b"},    32'(m_b),    32'(1) << mp[1]);
    check({where, ":idx_b"},  32'(idx_b),  32'(mp[1]));
    check({where, ":ovf_b"},  32'(ovf_b),  32'(ovf[1]));
    check({where, ":perr_b"}, 32'(perr_b), 32'(perr[1]));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit nc, input bit st, input bit s1);
    ncyc = nc; stall = st; set_m1 = s1;
    #1;
    check("t_last_a", 32'(t_last_a), 32'(tp[0] == tn[0] - 1));
    check("m_end_a",  32'(m_end_a),  32'(tp[0] == tn[0] - 1 && !st));
    check("t_last_b", 32'(t_last_b), 32'(tp[1] == tn[1] - 1));
    check("m_end_b",  32'(m_end_b),  32'(tp[1] == tn[1] - 1 && !st));
    @(posedge clk);
    model_edge(nc, st, s1);
    @(negedge clk);
    check_state("step");
  endtask

  task automatic do_reset();
    ncyc = 1'b0; stall = 1'b0; set_m1 = 1'b0;
    nreset = 1'b0;
    #2;
    model_reset();
    check_state("reset_async");
    @(negedge clk);
    check_state("reset_hold");
    nreset = 1'b1;
  endtask

  task automatic run_until(input int mt, input int tt);
    int n;
    n = 0;
    while (!(mp[0] == mt && tp[0] == tt) && n < 64) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("reach_target", 32'(mp[0] == mt && tp[0] == tt), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    ncyc = 1'b0; stall = 1'b0; set_m1 = 1'b0;
    nreset = 1'b0;
    model_reset();
    @(negedge clk);
    check_state("reset");
    nreset = 1'b1;

    // Free run from reset.
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (k == 1)  check("first_t2", 32'(t_a), 32'b0010);
      if (k == 4)  check("m2_at_4", 32'(m_a), 32'b000010);
      if (k == 5)  check("ovf_b_clk5", 32'(ovf_b), 32'd0);
      if (k == 6)  check("ovf_b_clk6", 32'(ovf_b), 32'd1);
      if (k == 20) check("m6_at_20", 32'(m_a), 32'b100000);
      if (k == 23) check("ovf_a_clk23", 32'(ovf_a), 32'd0);
      if (k == 24) begin
        check("ovf_a_clk24", 32'(ovf_a), 32'd1);
        check("m6_hold", 32'(m_a), 32'b100000);
      end
    end

    // Return to m1 from overflow, then set_m1 at t4 of m3.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    run_until(2, 3);
    step(1'b0, 1'b0, 1'b1);
    check("set_m1_m", 32'(m_a), 32'd1);
    check("set_m1_t", 32'(t_a), 32'd1);
    check("set_m1_idx", 32'(idx_a), 32'd0);
    check("set_m1_perr", 32'(perr_a), 32'd0);

    // Three stall cycles at t2 of m2 stretch that M-cycle to 7 clocks.
    run_until(1, 0);
    len = 0;
    step(1'b0, 1'b0, 1'b0); len++;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0); len++;
      check("stall_t2", 32'(t_a), 32'b0010);
    end
    while (idx_a == 3'd1 && len < 20) begin
      step(1'b0, 1'b0, 1'b0); len++;
    end
    check("m2_len", 32'(len), 32'd7);

    // Stall together with set_m1 at t4: held until the stall drops.
    run_until(2, 3);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b1);
      check("stall_set_m1_m", 32'(m_a), 32'b000100);
      check("stall_set_m1_t", 32'(t_a), 32'b1000);
    end
    step(1'b0, 1'b0, 1'b1);
    check("stall_release_m1", 32'(m_a), 32'd1);

    // ncyc mid-cycle restarts the M-cycle; ncyc with stall also goes to t1.
    run_until(3, 2);
    step(1'b1, 1'b0, 1'b0);
    check("ncyc_t", 32'(t_a), 32'd1);
    check("ncyc_m", 32'(m_a), 32'b001000);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("ncyc_stall_t", 32'(t_a), 32'd1);
    check("ncyc_stall_m", 32'(m_a), 32'b001000);

    // set_m1 at t2 is a protocol error and is otherwise ignored.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("perr_set", 32'(perr_a), 32'd1);
    check("perr_t3", 32'(t_a), 32'b0100);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
    check("perr_sticky", 32'(perr_a), 32'd1);

    // Randomised traffic, including occasional resets.
    for (int k = 0; k < 400; k++) begin
      bit nc, st, s1;
      if ($urandom_range(63) == 0) begin
        do_reset();
      end else begin
        nc = ($urandom_range(15) == 0);
        st = ($urandom_range(3) == 0);
        s1 = (tp[0] == tn[0] - 1) ? ($urandom_range(2) == 0) : ($urandom_range(24) == 0);
        step(nc, st, s1);
      end
    end

    // Asynchronous reset mid-clock with flags set and DUT B at m2/t2.
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("pre_async_m_b", 32'(m_b), 32'b010);
    check("pre_async_t_b", 32'(t_b), 32'b10);
    check("pre_async_perr_b", 32'(perr_b), 32'd1);
    #2;
    nreset = 1'b0;
    #1;
    model_reset();
    check_state("async_mid_clock");
    @(negedge clk);
    nreset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("post_reset_t2", 32'(t_a), 32'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sm83_seq_param.md
# sm83_seq_param

Parametrised machine-cycle / T-state sequencer for the SM83 core. It generalises the fixed 6-M-cycle, 4-T-state sequencer to configurable M-cycle and T-state counts. It adds automatic T-state wrap, a stall (wait) input and sticky protocol-error flags. It sits between the decoder/control unit (which drives `set_m1`, `stall` and `ncyc`) and every block that qualifies on one-hot M/T strobes.

## Interface

- `MCYC`, default 6: number of M-cycle states, legal range 2..16.
- `TSTATES`, default 4: T-states per M-cycle, legal range 2..8.
- `MW`, derived as `$clog2(MCYC)`: width of `m_idx`. Not overridable.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `ncyc` in 1: force the T phase back to t1 on the next edge (resync).
- `stall` in 1: freeze T and M state for this cycle (memory wait, HALT).
- `set_m1` in 1: return to m1 at the end of the current M-cycle. Legal only while `t_last`.
- `m` out MCYC: one-hot M-cycle; bit 0 = m1.
- `t` out TSTATES: one-hot T-state; bit 0 = t1.
- `m_idx` out MW: binary index of the active M-cycle (m1 = 0).
- `t_last` out 1: combinational, equals `t[TSTATES-1]`.
- `m_end` out 1: combinational, `t_last && !stall`. Marks the edge on which M advances.
- `m_ovf` out 1: sticky; set when M attempts to advance past `m[MCYC-1]`.
- `proto_err` out 1: sticky; set when `set_m1` is asserted while `!t_last`.

## Operation

- State consists of registered `t`, `m`, `m_idx`, `m_ovf` and `proto_err`. `m` and `m_idx` always agree.
- T-state update, in priority order:
  - `ncyc` loads t1.
  - otherwise `stall` holds `t`.
  - otherwise `t` rotates left one position; after `t[TSTATES-1]` it wraps to t1 automatically.
- M-cycle update happens only when `m_end`. `ncyc` does not affect whether M advances.
  - If `set_m1`: load m1 and set `m_idx` to 0.
  - Else if `m` is not the last M-cycle: shift one position and increment `m_idx` by 1.
  - Else (at `m[MCYC-1]`): hold at the last M-cycle and set `m_ovf`.
- When `m_end` is low, `m` and `m_idx` hold.
- `set_m1` while `!t_last`: ignored (no state change from it) and `proto_err` is set. The same applies if `stall` is high at the time.
- `set_m1` while `t_last && stall`: ignored and no error. The controller keeps it asserted until the stall releases.
- `m_ovf` and `proto_err` clear only on reset.
- Invariants to check with assertions:
  - `$onehot(t)` and `$onehot(m)` at all times.
  - `m_idx` equals the position of the set bit in `m`.
  - `m_end` implies `t_last`.
- Parameters outside the legal range are rejected by an elaboration-time check.

## Timing

- Reset values, applied asynchronously while `nreset` is low:
  - `t` = t1 (`'b0..01`)
  - `m` = m1
  - `m_idx` = 0
  - `m_ovf` = 0
  - `proto_err` = 0
- Release of `nreset` is synchronous to `clk`. The first rising edge after release advances t1 to t2, provided no `ncyc` or `stall`.
- An unstalled M-cycle lasts exactly TSTATES clocks. Each cycle with `stall` high adds one clock.
- Inputs sampled at edge k take effect in the state visible after edge k. Latency is one clock.
- `t_last` and `m_end` follow `t` and `stall` combinationally with zero latency. Downstream logic uses them only as edge qualifiers.
- Simultaneous `ncyc` and `stall`: `ncyc` wins for T (goes to t1). M holds because `m_end` is low.
- `ncyc` at `t_last` with no stall: T goes to t1 and M advances (same result as a natural wrap).
- `ncyc` mid-cycle: T goes to t1 and M is unchanged, so the current M-cycle restarts.
- Reset mid-M-cycle or while stalled: immediate return to the reset values. No partial update survives.

## Test plan

- MCYC=6, TSTATES=4, no stimulus after reset: observe 24 clocks.
  - `t` sequence is 0001,0010,0100,1000 repeating.
  - `m` walks m1..m6 in steps at clocks 4, 8, 12, 16, 20.
  - At clock 24 `m` holds at m6 and `m_ovf` becomes 1.
- Assert `set_m1` for one clock at t4 of m3: next state is m1/t1 and `m_idx`=0. `proto_err` stays 0.
- Assert `stall` for 3 clocks at t2 of m2: `t` holds at t2 for 3 extra clocks, `m` stays m2, and that M-cycle lasts 7 clocks. Then assert `stall` with `set_m1` at t4: no change until the stall drops, then m1.
- Assert `ncyc` at t3 of m4: next `t`=t1, `m`=m4 (the cycle restarts). Assert `ncyc` with `stall` at t2: next `t`=t1, `m` unchanged.
- Assert `set_m1` at t2: `proto_err`=1 on the next clock, `m`/`t` advance normally to t3, and `proto_err` stays 1 until `nreset` is pulsed.
- MCYC=3, TSTATES=2: period checks (2 clocks per M, `m_ovf` at clock 6). Pulse `nreset` low asynchronously mid-clock at m2/t2: outputs return to m1/t1 with both flags 0 before the next edge.
